rnn_layer_sequencer: RTL and testbench

Frame-level controller for the RNN denoise datapath. It fires the six layer engines in fixed dependency order, once per accepted feature frame, using a start-pulse/done-level handshake with each engine. The order is: dense1, gru1 (VAD GRU), dense2 (VAD output), noise GRU, denoise GRU, output dense. It also drives the select for the concatenated noise/denoise input buses and reports completion, VAD-valid and a watchdog error.

---
 rtl/rnn_layer_sequencer.sv | 143 ++++++++++++++
 tb/tb_rnn_layer_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// rnn_layer_sequencer : fires the RNN layer engines in dependency order once
//                       per accepted frame, with a per-layer watchdog.
// Revision 1.0
// ============================================================================
module rnn_layer_sequencer #(
   parameter int NUM_LAYERS     = 6,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  frame_valid_i,
   output logic                  frame_ready_o,
   output logic [NUM_LAYERS-1:0] layer_start_o,
   input  logic [NUM_LAYERS-1:0] layer_done_i,
   output logic [2:0]            cur_layer_o,
   output logic                  busy_o,
   output logic                  vad_valid_o,
   output logic                  frame_done_o,
   output logic                  timeout_err_o,
   output logic [2:0]            err_layer_o,
   input  logic                  err_clr_i,
   output logic [CNT_W-1:0]      frame_cnt_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   localparam int         TMO_W      = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [2:0] VAD_LAYER  = 3'd2;
   localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

   logic [2:0]       state_q,     state_d;
   logic [2:0]       cur_layer_q, cur_layer_d;
   logic [2:0]       err_layer_q, err_layer_d;
   logic [TMO_W-1:0] tmo_q,       tmo_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             done_cur;
   logic             tmo_hit;

   // Only the engine currently being waited on may advance the sequence.
   always_comb begin
      done_cur = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (cur_layer_q == 3'(i)) done_cur = layer_done_i[i];
      end
   end

   // Trips on the WAIT cycle where the incremented count reaches TIMEOUT_CYCLES-1,
   // so the error flag appears TIMEOUT_CYCLES cycles after the start pulse.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                    ((32'(tmo_q) + 32'd2) >= 32'(TIMEOUT_CYCLES));

   always_comb begin
      state_d     = state_q;
      cur_layer_d = cur_layer_q;
      err_layer_d = err_layer_q;
      tmo_d       = tmo_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (frame_valid_i) begin
               cur_layer_d = '0;
               state_d     = S_START;
            end
         end
         S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (done_cur) begin
               state_d = S_NEXT;
            end else if (tmo_hit) begin
               err_layer_d = cur_layer_q;
               state_d     = S_ERROR;
            end
         end
         S_NEXT: begin
            if (cur_layer_q == LAST_LAYER) begin
               state_d = S_DONE;
            end else begin
               cur_layer_d = cur_layer_q + 3'd1;
               state_d     = S_START;
            end
         end
         S_DONE: begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            cur_layer_d = '0;
            state_d     = S_IDLE;
         end
         S_ERROR: begin
            if (err_clr_i) begin
               err_layer_d = '0;
               cur_layer_d = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cur_layer_q <= '0;
         err_layer_q <= '0;
         tmo_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_layer_q <= cur_layer_d;
         err_layer_q <= err_layer_d;
         tmo_q       <= tmo_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      layer_start_o = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         layer_start_o[i] = (state_q == S_START) && (cur_layer_q == 3'(i));
      end
   end

   assign frame_ready_o = (state_q == S_IDLE);
   assign busy_o        = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_NEXT);
   assign vad_valid_o   = (state_q == S_NEXT) && (cur_layer_q == VAD_LAYER);
   assign frame_done_o  = (state_q == S_DONE);
   assign timeout_err_o = (state_q == S_ERROR);
   assign err_layer_o   = err_layer_q;
   assign cur_layer_o   = cur_layer_q;
   assign frame_cnt_o   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rnn_layer_sequencer : directed frames checked by a cycle-stamped event
//                          scoreboard (start / vad / frame_done / timeout).
// Revision 1.0
// ============================================================================
module tb_rnn_layer_sequencer;

   localparam int NL  = 6;
   localparam int TMO = 16;
   localparam int LAT = 6;   // engine done lands 6 cycles after its start cycle -> 8-cycle start spacing

   localparam int K_START = 0;
   localparam int K_VAD   = 1;
   localparam int K_FDONE = 2;
   localparam int K_TMO   = 3;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          frame_valid, frame_ready, busy, vad_valid, frame_done, timeout_err, err_clr;
   logic [NL-1:0] layer_start, layer_done;
   logic [2:0]    cur_layer, err_layer;
   logic [15:0]   frame_cnt;

   logic          frame_valid_w, frame_ready_w, busy_w, vad_valid_w, frame_done_w, timeout_err_w;
   logic [NL-1:0] layer_start_w;
   logic [NL-1:0] layer_done_w = '1;
   logic [2:0]    cur_layer_w, err_layer_w;
   logic [2:0]    frame_cnt_w;

   rnn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .frame_valid_i(frame_valid), .frame_ready_o(frame_ready),
      .layer_start_o(layer_start), .layer_done_i(layer_done),
      .cur_layer_o(cur_layer), .busy_o(busy), .vad_valid_o(vad_valid),
      .frame_done_o(frame_done), .timeout_err_o(timeout_err), .err_layer_o(err_layer),
      .err_clr_i(err_clr), .frame_cnt_o(frame_cnt)
   );

   // Narrow counter instance so the wrap-around is reachable in a short run.
   rnn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TMO), .CNT_W(3)) u_dut_w (
      .clk_i(clk), .rst_ni(rst_n),
      .frame_valid_i(frame_valid_w), .frame_ready_o(frame_ready_w),
      .layer_start_o(layer_start_w), .layer_done_i(layer_done_w),
      .cur_layer_o(cur_layer_w), .busy_o(busy_w), .vad_valid_o(vad_valid_w),
      .frame_done_o(frame_done_w), .timeout_err_o(timeout_err_w), .err_layer_o(err_layer_w),
      .err_clr_i(1'b0), .frame_cnt_o(frame_cnt_w)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- engine model ----------------
   int            eng_lat [NL];
   int            due     [NL];
   logic [NL-1:0] eng_dis, eng_done, force_done;
   assign layer_done = eng_done | force_done;

   always @(negedge clk or negedge rst_n) begin
      for (int i = 0; i < NL; i++) begin
         if (!rst_n) begin
            due[i]      = -1;
            eng_done[i] = 1'b0;
         end else begin
            if (layer_start[i] && !eng_dis[i]) due[i] = cyc + eng_lat[i];
            eng_done[i] = (cyc == due[i]);
         end
      end
   end

   // ---------------- scoreboard ----------------
   ev_t  sb [$];
   int   wq [$];
   logic cnt_pend = 1'b0;
   int   cnt_exp  = 0;
   logic wpend    = 1'b0;
   int   wexp     = 0;
   logic tmo_prev = 1'b0;

   task automatic push_frame(input int t, input int lat [NL], input int cnt, input int stop);
      int s;
      s = t + 1;
      for (int i = 0; i < NL; i++) begin
         sb.push_back('{K_START, s, i});
         if (i == stop) begin
            sb.push_back('{K_TMO, s + TMO, i});
            return;
         end
         if (i == 2) sb.push_back('{K_VAD, s + lat[i] + 1, 0});
         if (i == NL - 1) sb.push_back('{K_FDONE, s + lat[i] + 2, cnt});
         s = s + lat[i] + 2;
      end
   endtask

   task automatic expect_ev(input int kind, input int val, input string tag);
      ev_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_%s: got event value %0d at cycle %0d, expected no event", tag, val, cyc);
      end else begin
         e = sb.pop_front();
         check({tag, "_kind"}, kind, e.kind);
         check({tag, "_cycle"}, cyc, e.cyc);
         if (kind == K_START || kind == K_TMO) check({tag, "_value"}, val, e.val);
         if (kind == K_FDONE) begin
            cnt_pend = 1'b1;
            cnt_exp  = e.val;
         end
      end
   endtask

   function automatic int idx_of(input logic [NL-1:0] v);
      for (int i = 0; i < NL; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (cnt_pend) begin
            check("frame_cnt_after_done", frame_cnt, cnt_exp);
            check("ready_after_done", frame_ready, 1);
            cnt_pend = 1'b0;
         end
         if (layer_start != '0) begin
            check("start_onehot", $onehot(layer_start), 1);
            check("start_ready_low", frame_ready, 0);
            expect_ev(K_START, idx_of(layer_start), "start");
         end
         if (vad_valid) expect_ev(K_VAD, 0, "vad");
         if (frame_done) begin
            check("fdone_ready_low", frame_ready, 0);
            expect_ev(K_FDONE, 0, "fdone");
         end
         if (timeout_err && !tmo_prev) begin
            check("tmo_ready_low", frame_ready, 0);
            check("tmo_busy_low", busy, 0);
            expect_ev(K_TMO, err_layer, "timeout");
         end
         if (wpend) begin
            check("wrap_frame_cnt", frame_cnt_w, wexp);
            wpend = 1'b0;
         end
         if (frame_done_w) begin
            if (wq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_wrap_fdone: got frame_done at cycle %0d, expected none", cyc);
            end else begin
               wexp  = wq.pop_front();
               wpend = 1'b1;
            end
         end
      end
      tmo_prev = timeout_err;
   end

   // ---------------- stimulus ----------------
   int lat_v [NL];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (!frame_ready && k < budget) begin
         tick(1);
         k++;
      end
      check("idle_within_budget", frame_ready, 1);
      tick(2);
   endtask

   task automatic run_frame(input int cnt, input int stop);
      push_frame(cyc, lat_v, cnt, stop);
      frame_valid = 1'b1;
      tick(1);
      frame_valid = 1'b0;
      check("ready_low_after_accept", frame_ready, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, frame_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_start"}, layer_start, 0);
      check({tag, "_cur_layer"}, cur_layer, 0);
      check({tag, "_vad"}, vad_valid, 0);
      check({tag, "_fdone"}, frame_done, 0);
      check({tag, "_tmo"}, timeout_err, 0);
      check({tag, "_err_layer"}, err_layer, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
   endtask

   initial begin
      int t, k, nd;
      rst_n = 1'b0; frame_valid = 1'b0; err_clr = 1'b0; frame_valid_w = 1'b0;
      force_done = '0; eng_dis = '0;
      for (int i = 0; i < NL; i++) begin
         eng_lat[i] = LAT;
         lat_v[i]   = LAT;
      end
      tick(3);
      check_reset_values("reset");
      rst_n = 1'b1;
      tick(2);

      // single frame
      run_frame(1, -1);
      wait_idle(200);

      // back-to-back frames with frame_valid held
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      t = cyc;
      for (int f = 0; f < 3; f++) push_frame(t + 50 * f, lat_v, f + 1, -1);
      frame_valid = 1'b1;
      tick(101);
      frame_valid = 1'b0;
      wait_idle(200);

      // foreign done tied high on layer 4, stale done on layer 0 during START
      force_done[4] = 1'b1;
      lat_v[4] = 1;
      push_frame(cyc, lat_v, 4, -1);
      frame_valid = 1'b1;
      tick(1);
      frame_valid   = 1'b0;
      force_done[0] = 1'b1;
      tick(1);
      force_done[0] = 1'b0;
      wait_idle(200);
      force_done = '0;
      lat_v[4]   = LAT;

      // watchdog: layer 3 never completes
      eng_dis[3] = 1'b1;
      run_frame(0, 3);
      k = 0;
      while (!timeout_err && k < 100) begin
         tick(1);
         k++;
      end
      check("tmo_reached", timeout_err, 1);
      tick(3);
      check("tmo_sticky", timeout_err, 1);
      check("tmo_err_layer", err_layer, 3);
      check("tmo_ready_held_low", frame_ready, 0);
      check("tmo_no_start", layer_start, 0);
      check("tmo_cnt_kept", frame_cnt, 4);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("clr_tmo", timeout_err, 0);
      check("clr_err_layer", err_layer, 0);
      check("clr_ready", frame_ready, 1);
      check("clr_cnt_kept", frame_cnt, 4);
      eng_dis = '0;
      tick(2);

      // done on the final watchdog cycle wins; err_clr outside ERROR is inert
      eng_lat[3] = TMO - 1;
      lat_v[3]   = TMO - 1;
      err_clr    = 1'b1;
      run_frame(5, -1);
      wait_idle(300);
      err_clr = 1'b0;
      check("coincident_no_tmo", timeout_err, 0);
      eng_lat[3] = LAT;
      lat_v[3]   = LAT;

      // asynchronous reset while waiting on layer 2
      run_frame(6, -1);
      tick(17);
      check("mid_cur_layer", cur_layer, 2);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      sb.delete();
      cnt_pend = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(10);
      run_frame(1, -1);
      wait_idle(200);

      // counter wrap on the narrow instance: 7 -> 0 on the eighth frame
      for (int n = 1; n <= 9; n++) wq.push_back(n % 8);
      frame_valid_w = 1'b1;
      nd = 0;
      k  = 0;
      while (nd < 9 && k < 400) begin
         tick(1);
         k++;
         if (frame_done_w) nd++;
      end
      frame_valid_w = 1'b0;
      check("wrap_frames_done", nd, 9);
      tick(3);
      check("wrap_queue_drained", wq.size(), 0);
      check("wrap_no_error", timeout_err_w, 0);

      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "bench did not complete");
   end

endmodule
`default_nettype wire
